// File: rtl/ghost_collision_detect_if.sv
// Pixel-rate bundle between the raster draw requests, the collision detector
// and the ghost/score consumers.
interface ghost_collision_detect_if #(
    parameter int NUM_ROCKS = 4,
    parameter int HIT_CNT_W = 8
);
    logic                 startOfFrame;
    logic                 draw_ghost;
    logic [NUM_ROCKS-1:0] draw_rock;
    logic                 draw_border;
    logic                 collision;
    logic [NUM_ROCKS-1:0] rock_hit;
    logic                 border_hit;
    logic [HIT_CNT_W-1:0] hit_count;
    logic                 invulnerable;

    modport master (
        output startOfFrame, draw_ghost, draw_rock, draw_border,
        input  collision, rock_hit, border_hit, hit_count, invulnerable
    );

    modport slave (
        input  startOfFrame, draw_ghost, draw_rock, draw_border,
        output collision, rock_hit, border_hit, hit_count, invulnerable
    );
endinterface

// File: rtl/ghost_collision_detect.sv
// Ghost vs rock/border collision detector: one pulse per frame at most,
// frame-based cool-down, per-frame hit flags and a saturating hit counter.
module ghost_collision_detect #(
    parameter int NUM_ROCKS       = 4,
    parameter int COOLDOWN_FRAMES = 30,
    parameter int HIT_CNT_W       = 8
) (
    input  logic clk,
    input  logic resetN,
    ghost_collision_detect_if.slave cd
);
    localparam int CNT_W =
        (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN_FRAMES);

    typedef enum logic [1:0] {ARMED, FIRED, COOLDOWN} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_accept;
    logic [NUM_ROCKS-1:0] w_ovl_rock;
    logic                 w_ovl_border;
    logic                 w_any;
    logic [NUM_ROCKS-1:0] r_acc_rock;
    logic                 r_acc_border;
    logic [NUM_ROCKS-1:0] r_rock_hit;
    logic                 r_border_hit;
    logic                 r_collision;
    logic                 r_inv;
    logic [HIT_CNT_W-1:0] r_hit_count;

    assign w_ovl_rock   = {NUM_ROCKS{cd.draw_ghost}} & cd.draw_rock;
    assign w_ovl_border = cd.draw_ghost & cd.draw_border;
    assign w_any        = (|w_ovl_rock) | w_ovl_border;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        unique case (r_state)
            ARMED: begin
                if (w_any) begin
                    w_accept    = 1'b1;
                    w_state_nxt = FIRED;
                end
            end
            FIRED: begin
                if (cd.startOfFrame) begin
                    if (COOLDOWN_FRAMES == 0) begin
                        // re-armed at the frame start, so this pixel counts
                        w_accept    = w_any;
                        w_state_nxt = w_any ? FIRED : ARMED;
                    end else begin
                        w_state_nxt = COOLDOWN;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            COOLDOWN: begin
                if (cd.startOfFrame) begin
                    if ((r_cnt == '0) || (r_cnt == CNT_W'(1))) begin
                        w_cnt_nxt   = '0;
                        w_accept    = w_any;
                        w_state_nxt = w_any ? FIRED : ARMED;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = ARMED;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state      <= ARMED;
            r_cnt        <= '0;
            r_acc_rock   <= '0;
            r_acc_border <= 1'b0;
            r_rock_hit   <= '0;
            r_border_hit <= 1'b0;
            r_collision  <= 1'b0;
            r_inv        <= 1'b0;
            r_hit_count  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_collision <= w_accept;
            r_inv       <= (w_state_nxt == COOLDOWN);
            if (w_accept && (r_hit_count != '1)) begin
                r_hit_count <= r_hit_count + HIT_CNT_W'(1);
            end
            // a frame-start overlap belongs to the new frame
            if (cd.startOfFrame) begin
                r_rock_hit   <= r_acc_rock;
                r_border_hit <= r_acc_border;
                r_acc_rock   <= w_ovl_rock;
                r_acc_border <= w_ovl_border;
            end else begin
                r_acc_rock   <= r_acc_rock | w_ovl_rock;
                r_acc_border <= r_acc_border | w_ovl_border;
            end
        end
    end

    assign cd.collision    = r_collision;
    assign cd.rock_hit     = r_rock_hit;
    assign cd.border_hit   = r_border_hit;
    assign cd.hit_count    = r_hit_count;
    assign cd.invulnerable = r_inv;
endmodule

// File: tb/tb_ghost_collision_detect.sv
// Directed bench: unit A uses a 2-frame cool-down, unit B has no cool-down
// and a 2-bit hit counter.
module tb_ghost_collision_detect;
    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    ghost_collision_detect_if #(.NUM_ROCKS(4), .HIT_CNT_W(8)) ia ();
    ghost_collision_detect_if #(.NUM_ROCKS(4), .HIT_CNT_W(2)) ib ();

    ghost_collision_detect #(
        .NUM_ROCKS(4), .COOLDOWN_FRAMES(2), .HIT_CNT_W(8)
    ) u_a (
        .clk(clk), .resetN(rst_a), .cd(ia.slave)
    );

    ghost_collision_detect #(
        .NUM_ROCKS(4), .COOLDOWN_FRAMES(0), .HIT_CNT_W(2)
    ) u_b (
        .clk(clk), .resetN(rst_b), .cd(ib.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Outputs sampled 1 time unit after the edge that registered the inputs.
    task automatic step_a(input logic sof, input logic g,
                          input logic [3:0] r, input logic b);
        ia.startOfFrame = sof;
        ia.draw_ghost   = g;
        ia.draw_rock    = r;
        ia.draw_border  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic sof, input logic g,
                          input logic [3:0] r, input logic b);
        ib.startOfFrame = sof;
        ib.draw_ghost   = g;
        ib.draw_rock    = r;
        ib.draw_border  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst_a();
        rst_a = 1'b0;
        #2;
        rst_a = 1'b1;
    endtask

    initial begin
        logic [1:0] sat_exp [5];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        ia.startOfFrame = 0; ia.draw_ghost = 0;
        ia.draw_rock = '0;   ia.draw_border = 0;
        ib.startOfFrame = 0; ib.draw_ghost = 0;
        ib.draw_rock = '0;   ib.draw_border = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_coll", ia.collision, 0);
        chk("rst_hits", ia.hit_count, 0);
        chk("rst_inv", ia.invulnerable, 0);
        chk("rst_rock", ia.rock_hit, 0);
        chk("rst_bord", ia.border_hit, 0);
        rst_a = 1'b1;

        // single overlap held for 3 pixels around cycle 100
        repeat (97) step_a(0, 0, 4'b0000, 0);
        chk("t1_pre_coll", ia.collision, 0);
        step_a(0, 1, 4'b0010, 0);
        chk("t1_coll", ia.collision, 1);
        chk("t1_hits", ia.hit_count, 1);
        step_a(0, 1, 4'b0010, 0);
        chk("t1_coll2", ia.collision, 0);
        step_a(0, 1, 4'b0010, 0);
        chk("t1_coll3", ia.collision, 0);
        chk("t1_hits3", ia.hit_count, 1);
        step_a(0, 0, 4'b0000, 0);
        step_a(1, 0, 4'b0000, 0);
        chk("t1_rockhit", ia.rock_hit, 4'b0010);
        chk("t1_inv", ia.invulnerable, 1);
        step_a(0, 0, 4'b0000, 0);
        step_a(1, 0, 4'b0000, 0);
        chk("t1_rockclr", ia.rock_hit, 4'b0000);

        // cool-down over frames 0..4
        pulse_rst_a();
        for (int f = 0; f < 5; f++) begin
            step_a(1, 0, 4'b0000, 0);
            chk($sformatf("t2_inv_f%0d", f), ia.invulnerable,
                (f == 1 || f == 2 || f == 4) ? 1 : 0);
            step_a(0, 1, 4'b0001, 0);
            chk($sformatf("t2_coll_f%0d", f), ia.collision,
                (f == 0 || f == 3) ? 1 : 0);
            chk($sformatf("t2_hits_f%0d", f), ia.hit_count,
                (f < 3) ? 1 : 2);
            step_a(0, 0, 4'b0000, 0);
            chk($sformatf("t2_off_f%0d", f), ia.collision, 0);
        end

        // border then rocks 0 and 3 in one frame
        pulse_rst_a();
        step_a(0, 1, 4'b0000, 1);
        chk("t3_coll", ia.collision, 1);
        step_a(0, 0, 4'b0000, 0);
        step_a(0, 1, 4'b0001, 0);
        chk("t3_coll_r0", ia.collision, 0);
        step_a(0, 1, 4'b1000, 0);
        chk("t3_coll_r3", ia.collision, 0);
        step_a(1, 0, 4'b0000, 0);
        chk("t3_border", ia.border_hit, 1);
        chk("t3_rocks", ia.rock_hit, 4'b1001);
        chk("t3_hits", ia.hit_count, 1);

        // reach hit_count=7 inside a cool-down, then reset asynchronously
        pulse_rst_a();
        for (int k = 0; k < 7; k++) begin
            step_a(0, 1, 4'b0001, 0);
            step_a(1, 0, 4'b0000, 0);
            if (k < 6) begin
                step_a(1, 0, 4'b0000, 0);
                step_a(1, 0, 4'b0000, 0);
            end
        end
        chk("t4_hits7", ia.hit_count, 7);
        chk("t4_inv", ia.invulnerable, 1);
        rst_a = 1'b0;
        #1;
        chk("t4_r_hits", ia.hit_count, 0);
        chk("t4_r_inv", ia.invulnerable, 0);
        chk("t4_r_rock", ia.rock_hit, 0);
        chk("t4_r_coll", ia.collision, 0);
        #1;
        rst_a = 1'b1;
        step_a(0, 1, 4'b0010, 0);
        chk("t4_coll", ia.collision, 1);
        chk("t4_hits", ia.hit_count, 1);

        // unit B: saturation with no cool-down
        step_b(0, 0, 4'b0000, 0);
        chk("b_rst_hits", ib.hit_count, 0);
        rst_b = 1'b1;
        for (int f = 0; f < 5; f++) begin
            step_b(1, 0, 4'b0000, 0);
            step_b(0, 1, 4'b0001, 0);
            chk($sformatf("b_coll_f%0d", f), ib.collision, 1);
            chk($sformatf("b_hits_f%0d", f), ib.hit_count, sat_exp[f]);
            step_b(0, 0, 4'b0000, 0);
        end

        // overlap on the frame-start pixel while FIRED
        step_b(0, 1, 4'b0001, 0);
        chk("b_fired_coll", ib.collision, 0);
        step_b(1, 1, 4'b0100, 0);
        chk("b_sof_coll", ib.collision, 1);
        chk("b_old_frame", ib.rock_hit, 4'b0001);
        step_b(0, 0, 4'b0000, 0);
        chk("b_coll_off", ib.collision, 0);
        step_b(1, 0, 4'b0000, 0);
        chk("b_new_frame", ib.rock_hit, 4'b0100);
        chk("b_hits_sat", ib.hit_count, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ghost_collision_detect.md
# ghost_collision_detect

Pixel-rate collision detector that sits directly upstream of the ghost object unit and drives its `collision` input. It compares the ghost's per-pixel draw request against the rock and border draw requests during the raster scan. It emits at most one single-cycle collision pulse per frame. A configurable invulnerability cool-down is applied after each hit, and the block keeps per-rock hit flags and a saturating hit counter for the score/lives logic.

## Interface
- `NUM_ROCKS`, 4: number of rock draw-request inputs (1..8).
- `COOLDOWN_FRAMES`, 30: frames after a hit during which new hits are ignored (0 = no cool-down).
- `HIT_CNT_W`, 8: width of the hit counter.
- `clk`  in  1  pixel clock, rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `startOfFrame`  in  1  one-cycle pulse at the first pixel of each frame.
- `draw_ghost`  in  1  ghost draw request for the current pixel (the ghost unit's `Draw`).
- `draw_rock`  in  NUM_ROCKS  per-rock draw requests for the current pixel.
- `draw_border`  in  1  border/frame draw request for the current pixel.
- `collision`  out  1  one-cycle pulse to the ghost unit's `collision` input.
- `rock_hit`  out  NUM_ROCKS  rocks overlapped by the ghost in the previous frame; held for one frame.
- `border_hit`  out  1  ghost overlapped the border in the previous frame; held for one frame.
- `hit_count`  out  HIT_CNT_W  total accepted hits, saturating.
- `invulnerable`  out  1  high while the cool-down is active.

## Operation
- Overlap term: `ovl_rock[i] = draw_ghost & draw_rock[i]`. Overlap term: `ovl_border = draw_ghost & draw_border`. Any-overlap is the OR of all overlap terms.
- State machine states:
  - ARMED: no hit accepted yet this frame.
  - FIRED: a hit has been accepted this frame.
  - COOLDOWN: waiting out the invulnerability frames.
- ARMED: any-overlap in a cycle → register `collision`=1 for exactly one cycle, increment `hit_count` (saturate at all-ones), go to FIRED.
- FIRED: further overlaps produce no pulse and no count. On `startOfFrame`:
  - COOLDOWN_FRAMES=0 → ARMED.
  - Otherwise → COOLDOWN, with the cool-down counter loaded to COOLDOWN_FRAMES.
- COOLDOWN: overlaps are ignored for pulse and count purposes. Each `startOfFrame` decrements the counter. When the counter reaches 0 at a `startOfFrame`, go to ARMED; that frame is already armed.
- `invulnerable` = (state == COOLDOWN).
- Frame accumulators record sticky overlaps during the current frame in every state, for diagnostics and scoring:
  - `acc_rock` ORs in `ovl_rock`.
  - `acc_border` ORs in `ovl_border`.
- On `startOfFrame`, the accumulators are copied to `rock_hit`/`border_hit`, then cleared. If an overlap occurs in the same cycle as `startOfFrame`, it is written into the cleared accumulator; it belongs to the new frame.
- Simultaneous `startOfFrame` and overlap in FIRED with COOLDOWN_FRAMES=0: the transition to ARMED happens first and the overlap is accepted in the same cycle. The pulse comes out on the next cycle and the state goes to FIRED.
- Overlap in the cycle COOLDOWN expires at `startOfFrame`: accepted as in ARMED.
- No `startOfFrame` ever: FIRED/COOLDOWN persist indefinitely. This is legal and produces no spurious pulses.
- X/Y coordinates are not needed; overlap is purely per-pixel coincidence of draw requests.

## Timing
- All outputs registered.
- `collision` rises 1 cycle after the overlapping pixel and is high for exactly 1 cycle.
- `hit_count` updates in the same cycle `collision` is high.
- `rock_hit`/`border_hit`/`invulnerable` change 1 cycle after the `startOfFrame` pulse that triggers them.
- Reset (asynchronous assert, any time including mid-frame or mid-cool-down):
  - state=ARMED, cool-down counter=0.
  - accumulators=0.
  - `collision`=0, `rock_hit`=0, `border_hit`=0, `hit_count`=0, `invulnerable`=0.
- After reset release, the first overlap is accepted without waiting for `startOfFrame`.
- Cool-down counter width is ceil(log2(COOLDOWN_FRAMES+1)), with a minimum of 1 bit.

## Test plan
- Single overlap: NUM_ROCKS=4. `draw_ghost`=1 and `draw_rock`=4'b0010 for 3 consecutive cycles at cycle 100 → `collision` high only at cycle 101 and `hit_count`=1. After the next `startOfFrame`, `rock_hit`=4'b0010.
- Cool-down: COOLDOWN_FRAMES=2, overlap on every frame 0..4 → pulses in frames 0 and 3 only, `hit_count`=2. `invulnerable` high from frame 1 start through frame 2, low at frame 3 start.
- Same-cycle boundary: COOLDOWN_FRAMES=0, in FIRED. Overlap coincides with `startOfFrame` → `collision` pulse on the next cycle. The overlap appears in the accumulators of the new frame, not the old one.
- Border and multiple rocks in one frame: border overlap, then rocks 0 and 3 overlap later → 1 pulse. Next frame: `border_hit`=1, `rock_hit`=4'b1001.
- Saturation: HIT_CNT_W=2, COOLDOWN_FRAMES=0, 5 frames each with an overlap → `hit_count` sequence 1,2,3,3,3.
- Reset mid-cool-down: assert `resetN`=0 during COOLDOWN with `hit_count`=7 → all outputs 0 immediately. After release, an overlap in the same frame pulses `collision`.
